norm_arbiter: RTL and testbench

NORM_ARBITER -- requirements
Module: norm_arbiter

---
 rtl/norm_arbiter.sv | 159 +++++++++++++++
 tb/tb_norm_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : norm_arbiter
// Description : Round-robin arbiter sharing one pipelined normalizer between
//               two requesters, with tag tracking, flush/drain and idle status.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_arbiter #(
    parameter int SIZE_MANTISSA = 24,
    parameter int SIZE_EXPONENT = 8,
    parameter int LATENCY       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [SIZE_MANTISSA:0]     req0_m,
    input  logic [SIZE_MANTISSA-1:0]   req0_rb,
    input  logic [SIZE_EXPONENT:0]     req0_e,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [SIZE_MANTISSA:0]     req1_m,
    input  logic [SIZE_MANTISSA-1:0]   req1_rb,
    input  logic [SIZE_EXPONENT:0]     req1_e,
    output logic                       unit_issue,
    output logic [SIZE_MANTISSA:0]     unit_m,
    output logic [SIZE_MANTISSA-1:0]   unit_rb,
    output logic [SIZE_EXPONENT:0]     unit_e,
    input  logic [SIZE_MANTISSA-1:0]   unit_res_m,
    input  logic [SIZE_EXPONENT-1:0]   unit_res_e,
    output logic                       resp0_valid,
    output logic                       resp1_valid,
    output logic [SIZE_MANTISSA-1:0]   resp_m,
    output logic [SIZE_EXPONENT-1:0]   resp_e,
    input  logic                       flush,
    output logic                       idle
);

    localparam int               c_CNT_W    = $clog2(LATENCY + 1) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_last_grant;
    logic [LATENCY-1:0] r_sr_valid;
    logic [LATENCY-1:0] r_sr_tag;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_allow;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic               w_resp;
    logic               w_resp_tag;

    // On a tie the requester not granted most recently wins.
    assign w_allow    = !flush && (r_state != c_ST_DRAIN);
    assign w_gnt0     = w_allow && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1     = w_allow && req1_valid && (!req0_valid || !r_last_grant);
    assign w_issue    = w_gnt0 || w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign unit_issue = w_issue;

    assign w_resp     = r_sr_valid[LATENCY-1];
    assign w_resp_tag = r_sr_tag[LATENCY-1];
    assign idle       = (r_state == c_ST_IDLE) && (r_count == '0);

    always_comb begin
        unit_m  = '0;
        unit_rb = '0;
        unit_e  = '0;
        if (w_gnt0) begin
            unit_m  = req0_m;
            unit_rb = req0_rb;
            unit_e  = req0_e;
        end else if (w_gnt1) begin
            unit_m  = req1_m;
            unit_rb = req1_rb;
            unit_e  = req1_e;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_issue, w_resp})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RUN: begin
                if (flush) begin
                    w_state_next = (w_count_next != '0) ? c_ST_DRAIN : c_ST_IDLE;
                end else if (w_issue) begin
                    w_state_next = c_ST_RUN;
                end else if (w_count_next == '0) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DRAIN: begin
                // Stay draining while flush is held, even once empty.
                if (!flush && (w_count_next == '0)) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_sr_valid   <= '0;
            r_sr_tag     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            if (w_issue) begin
                r_last_grant <= w_gnt1;
            end
            r_sr_valid[0] <= w_issue;
            r_sr_tag[0]   <= w_gnt1;
            for (int i = 1; i < LATENCY; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_tag[i]   <= r_sr_tag[i-1];
            end
        end
    end

    // Result fields hold their last value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_m      <= '0;
            resp_e      <= '0;
        end else begin
            resp0_valid <= w_resp && !w_resp_tag;
            resp1_valid <= w_resp && w_resp_tag;
            if (w_resp) begin
                resp_m <= unit_res_m;
                resp_e <= unit_res_e;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_arbiter
// Description : Scoreboard bench for norm_arbiter with a leading-zero
//               normalizer model of matching pipeline depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_arbiter;

    localparam int M   = 24;
    localparam int E   = 8;
    localparam int LAT = 2;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [M:0]     req0_m = '0, req1_m = '0;
    logic [M-1:0]   req0_rb = '0, req1_rb = '0;
    logic [E:0]     req0_e = '0, req1_e = '0;
    logic           unit_issue;
    logic [M:0]     unit_m;
    logic [M-1:0]   unit_rb;
    logic [E:0]     unit_e;
    logic [M-1:0]   unit_res_m;
    logic [E-1:0]   unit_res_e;
    logic           resp0_valid, resp1_valid;
    logic [M-1:0]   resp_m;
    logic [E-1:0]   resp_e;
    logic           flush = 1'b0;
    logic           idle;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int resp_seen = 0;

    typedef struct {
        logic         tag;
        logic [M-1:0] m;
        logic [E-1:0] e;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    norm_arbiter #(.SIZE_MANTISSA(M), .SIZE_EXPONENT(E), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_m(req0_m), .req0_rb(req0_rb), .req0_e(req0_e),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_m(req1_m), .req1_rb(req1_rb), .req1_e(req1_e),
        .unit_issue(unit_issue), .unit_m(unit_m), .unit_rb(unit_rb), .unit_e(unit_e),
        .unit_res_m(unit_res_m), .unit_res_e(unit_res_e),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_m(resp_m), .resp_e(resp_e),
        .flush(flush), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Normalizer model: leading one moved to the carry bit, top M bits kept;
    // the exponent is referenced two positions above the shift count.
    function automatic int lzc(input logic [M:0] m);
        lzc = M + 1;
        for (int i = 0; i <= M; i++) if (m[i]) lzc = M - i;
    endfunction

    function automatic logic [M-1:0] norm_m(input logic [M:0] m);
        logic [2*M+1:0] s;
        s = {{(M+1){1'b0}}, m} << lzc(m);
        norm_m = s[M:1];
    endfunction

    function automatic logic [E-1:0] norm_e(input logic [M:0] m, input logic [E:0] e);
        int t;
        t = int'(e) + 2 - lzc(m);
        norm_e = t[E-1:0];
    endfunction

    logic [M:0] p_m [LAT];
    logic [E:0] p_e [LAT];
    always @(posedge clk) begin
        p_m[0] <= unit_m;
        p_e[0] <= unit_e;
        for (int i = 1; i < LAT; i++) begin
            p_m[i] <= p_m[i-1];
            p_e[i] <= p_e[i-1];
        end
    end
    always_comb begin
        unit_res_m = norm_m(p_m[LAT-1]);
        unit_res_e = norm_e(p_m[LAT-1], p_e[LAT-1]);
    end

    // Scoreboard: push on accepted operand, pop and compare on response.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp0_valid || resp1_valid) begin
                exp_t x;
                resp_seen = resp_seen + 1;
                n_tests = n_tests + 1;
                if (resp0_valid && resp1_valid) begin
                    n_fail = n_fail + 1;
                    $display("FAIL resp_onehot: both resp valids high at cycle %0d", cyc);
                end else if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL resp_unexpected: response at cycle %0d with nothing expected", cyc);
                end else begin
                    x = sb.pop_front();
                    if (resp1_valid !== x.tag || resp_m !== x.m || resp_e !== x.e ||
                        cyc !== x.cyc + LAT + 1) begin
                        n_fail = n_fail + 1;
                        $display("FAIL resp_data: got tag=%0d m=%h e=%h cyc=%0d, want tag=%0d m=%h e=%h cyc=%0d",
                                 resp1_valid, resp_m, resp_e, cyc, x.tag, x.m, x.e, x.cyc + LAT + 1);
                    end
                end
            end
            if (req0_valid && req0_ready)
                sb.push_back('{1'b0, norm_m(req0_m), norm_e(req0_m, req0_e), cyc});
            if (req1_valid && req1_ready)
                sb.push_back('{1'b1, norm_m(req1_m), norm_e(req1_m, req1_e), cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [M:0] m0,
                         input logic [M:0] m1, input logic [E:0] e0, input logic [E:0] e1);
        req0_valid = v0; req1_valid = v1;
        req0_m = m0; req1_m = m1;
        req0_e = e0; req1_e = e1;
        req0_rb = m0[M-1:0] ^ 24'h5A5A5A;
        req1_rb = m1[M-1:0] ^ 24'hA5A5A5;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!idle && k < 20) begin
            tick();
            k++;
        end
        @(negedge clk);
        n_tests = n_tests + 1;
        if (idle !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL wait_idle: idle=%b after %0d cycles, want 1", idle, k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests = n_tests + 1;
        if (idle !== 1'b1 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0 ||
            resp_m !== '0 || resp_e !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_state: idle=%b r0=%b r1=%b m=%h e=%h, want 1 0 0 0 0",
                     idle, resp0_valid, resp1_valid, resp_m, resp_e);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 25'h100 + 25'(k), 25'h1200 + 25'(k), 9'd60 + 9'(k), 9'd90 + 9'(k));
            @(negedge clk);
            n_tests = n_tests + 1;
            if (req0_ready !== ~k[0] || req1_ready !== k[0] || unit_issue !== 1'b1 ||
                unit_m !== (k[0] ? req1_m : req0_m)) begin
                n_fail = n_fail + 1;
                $display("FAIL rr_grant[%0d]: rdy0=%b rdy1=%b issue=%b unit_m=%h, want %b %b 1 %h",
                         k, req0_ready, req1_ready, unit_issue, unit_m, ~k[0], k[0],
                         k[0] ? req1_m : req0_m);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        wait_idle();
    endtask

    task automatic test_single_requester();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, '0, 25'h0_40_0000 + 25'(k), '0, 9'd40);
            @(negedge clk);
            n_tests = n_tests + 1;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL single_req1[%0d]: rdy0=%b rdy1=%b, want 0 1", k, req0_ready, req1_ready);
            end
            tick();
        end
        drive(1'b1, 1'b1, 25'h0_00_0F00, 25'h0_00_00F0, 9'd70, 9'd71);
        @(negedge clk);
        n_tests = n_tests + 1;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL tie_after_req1: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        wait_idle();
    endtask

    task automatic test_norm();
        tick();
        drive(1'b1, 1'b0, 25'h0_00_0001, '0, 9'd30, '0);
        @(negedge clk);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_tests = n_tests + 1;
            if (k == 3) begin
                if (resp0_valid !== 1'b1 || resp_m !== 24'h800000 || resp_e !== 8'd8) begin
                    n_fail = n_fail + 1;
                    $display("FAIL norm_result: v=%b m=%h e=%0d, want 1 800000 8", resp0_valid, resp_m, resp_e);
                end
            end else if (k == 4) begin
                if (resp0_valid !== 1'b0 || resp_m !== 24'h800000 || resp_e !== 8'd8) begin
                    n_fail = n_fail + 1;
                    $display("FAIL norm_hold: v=%b m=%h e=%0d, want 0 800000 8", resp0_valid, resp_m, resp_e);
                end
            end else if (resp0_valid !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL norm_early[t+%0d]: resp0_valid=%b, want 0", k, resp0_valid);
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_flush();
        int seen0;
        tick();
        seen0 = resp_seen;
        drive(1'b1, 1'b1, 25'h0_12_3456, 25'h0_00_789A, 9'd100, 9'd120);
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_tests = n_tests + 1;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || unit_issue !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_no_grant: rdy0=%b rdy1=%b issue=%b, want 0 0 0",
                     req0_ready, req1_ready, unit_issue);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests = n_tests + 1;
        if (dut.r_state !== ST_DRAIN || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_state: state=%0d rdy0=%b rdy1=%b, want %0d 0 0",
                     dut.r_state, req0_ready, req1_ready, ST_DRAIN);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        n_tests = n_tests + 1;
        if (idle !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_idle: idle=%b, want 1", idle);
        end
        tick();
        @(negedge clk);
        n_tests = n_tests + 1;
        if (resp_seen - seen0 !== 2) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_resp_count: got %0d responses, want 2", resp_seen - seen0);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 25'h0_01_0000 << k, '0, 9'd50 + 9'(k), '0);
            @(negedge clk);
            n_tests = n_tests + 1;
            if (req0_ready !== 1'b1 ||
                (k >= 2 && (dut.r_count !== 3'(LAT) || dut.r_state !== ST_RUN))) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b[%0d]: rdy0=%b count=%0d state=%0d, want 1 %0d %0d",
                         k, req0_ready, dut.r_count, dut.r_state, LAT, ST_RUN);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int seen0;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 25'h0_00_0300 + 25'(k), 25'h0_03_0000 + 25'(k), 9'd80, 9'd81);
            tick();
        end
        n_tests = n_tests + 1;
        if ((resp0_valid | resp1_valid) !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_mid_pre: resp valid=%b, want 1", resp0_valid | resp1_valid);
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        sb.delete();
        #1;
        n_tests = n_tests + 1;
        if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || idle !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_mid_clear: r0=%b r1=%b idle=%b, want 0 0 1", resp0_valid, resp1_valid, idle);
        end
        tick();
        tick();
        rst = 1'b0;
        seen0 = resp_seen;
        repeat (6) tick();
        @(negedge clk);
        n_tests = n_tests + 1;
        if (resp_seen !== seen0 || idle !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_mid_after: responses=%0d idle=%b, want 0 1", resp_seen - seen0, idle);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_requester();
        test_norm();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        n_tests = n_tests + 1;
        if (sb.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_empty: %0d expected responses outstanding, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
